// File: rtl/cpu_execute_mc.sv
// Execute stage (2a -> 3a) of the stack-machine pipeline: single-cycle ALU plus an
// iterative MUL/DIVU/REMU unit that stalls stage 2a while it runs.
module cpu_execute_mc #(
  parameter int W      = 32,
  parameter int TAG    = 3,
  parameter int INSN_W = 48,
  parameter int POP_W  = 11,
  parameter int PUSH_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_2a,
  output logic              stall_2a,
  input  logic [4:0]        alu__op_2a,
  input  logic [1:0]        c__alu_left_2a,
  input  logic [1:0]        c__alu_right_2a,
  input  logic [1:0]        c__branch_2a,
  input  logic [PUSH_W-1:0] c__to_push_2a,
  input  logic [POP_W-1:0]  st__to_pop_2a,
  input  logic              c__r0_2a,
  input  logic              c__r1_2a,
  input  logic [INSN_W-1:0] instruction_2a,
  input  logic [31:0]       pc_2a,
  input  logic [W+TAG-1:0]  st__top_0_2a,
  input  logic [W+TAG-1:0]  st__top_1_2a,
  input  logic              kill_4a,
  output logic              valid_3a,
  output logic              alu__cond_3a,
  output logic [W-1:0]      alu__out_3a,
  output logic [1:0]        c__branch_3a,
  output logic [PUSH_W-1:0] c__to_push_3a,
  output logic [POP_W-1:0]  st__to_pop_3a,
  output logic [INSN_W-1:0] instruction_3a,
  output logic [31:0]       pc_3a,
  output logic [W+TAG-1:0]  r0_3a,
  output logic [W+TAG-1:0]  r1_3a
);

  localparam int SW = $clog2(W);
  localparam int CW = (SW < 1) ? 1 : SW;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_EQ   = 5'd7;
  localparam logic [4:0] OP_LTU  = 5'd8;
  localparam logic [4:0] OP_LTS  = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_DIVU = 5'd17;
  localparam logic [4:0] OP_REMU = 5'd18;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {MC_MUL, MC_DIVU, MC_REMU} mc_op_e;

  state_e            state_q;
  mc_op_e            mc_op_q;
  logic [CW-1:0]     cnt_q;
  logic [W-1:0]      acc_q, a_q, b_q;

  logic [1:0]        lat_branch;
  logic [PUSH_W-1:0] lat_push;
  logic [POP_W-1:0]  lat_pop;
  logic              lat_c_r0, lat_c_r1;
  logic [INSN_W-1:0] lat_insn;
  logic [31:0]       lat_pc;
  logic [W+TAG-1:0]  lat_r0, lat_r1;

  assign stall_2a = (state_q == BUSY);

  logic [W-1:0] left, right;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    left  = '0;
    right = '0;
    case (c__alu_left_2a)
      2'd0:    left = instruction_2a[W-1:0];
      2'd1:    left = st__top_0_2a[W-1:0];
      2'd2:    left = st__top_1_2a[W-1:0];
      default: left = '0;
    endcase
    case (c__alu_right_2a)
      2'd0:    right = instruction_2a[W-1:0];
      2'd1:    right = st__top_0_2a[W-1:0];
      2'd2:    right = st__top_1_2a[W-1:0];
      default: right = '0;
    endcase
  end

  logic [W-1:0] sc_out;
  logic         sc_cond;
  logic         is_multi;
  mc_op_e       mc_op_in;

  always_comb begin
    sc_out   = '0;
    sc_cond  = 1'b0;
    is_multi = 1'b0;
    mc_op_in = MC_MUL;
    case (alu__op_2a)
      OP_ADD:  sc_out = left + right;
      OP_SUB:  sc_out = left - right;
      OP_AND:  sc_out = left & right;
      OP_OR:   sc_out = left | right;
      OP_XOR:  sc_out = left ^ right;
      OP_SHL:  sc_out = left << right[SW-1:0];
      OP_SHR:  sc_out = left >> right[SW-1:0];
      OP_EQ:   sc_cond = (left == right);
      OP_LTU:  sc_cond = (left < right);
      OP_LTS:  sc_cond = ($signed(left) < $signed(right));
      OP_MUL:  begin is_multi = 1'b1; mc_op_in = MC_MUL;  end
      OP_DIVU: begin is_multi = 1'b1; mc_op_in = MC_DIVU; end
      OP_REMU: begin is_multi = 1'b1; mc_op_in = MC_REMU; end
      default: ;
    endcase
    // Arithmetic/logic ops flag a nonzero result; compares return the flag as a 0/1 word.
    if (alu__op_2a <= OP_SHR)
      sc_cond = |sc_out;
    else if (alu__op_2a >= OP_EQ && alu__op_2a <= OP_LTS)
      sc_out = W'(sc_cond);
  end

  // One iteration of the shared multi-cycle datapath. MUL: acc += a when b[0], a <<= 1, b >>= 1.
  // DIVU/REMU: acc is the partial remainder, a the divisor, b shifts the dividend out and the quotient in.
  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         ge;
  logic [W-1:0] it_acc, it_a, it_b;
  logic [W-1:0] mc_result;

  always_comb begin
    shifted = {acc_q, b_q[W-1]};
    ge      = (shifted >= {1'b0, a_q});
    diff    = shifted[W-1:0] - a_q;
    it_acc  = acc_q;
    it_a    = a_q;
    it_b    = b_q;
    if (mc_op_q == MC_MUL) begin
      it_acc = acc_q + (b_q[0] ? a_q : '0);
      it_a   = a_q << 1;
      it_b   = b_q >> 1;
    end else begin
      it_acc = ge ? diff : shifted[W-1:0];
      it_b   = {b_q[W-2:0], ge};
    end
    case (mc_op_q)
      MC_DIVU: mc_result = it_b;
      default: mc_result = it_acc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mc_op_q        <= MC_MUL;
      cnt_q          <= '0;
      acc_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      lat_branch     <= '0;
      lat_push       <= '0;
      lat_pop        <= '0;
      lat_c_r0       <= 1'b0;
      lat_c_r1       <= 1'b0;
      lat_insn       <= '0;
      lat_pc         <= '0;
      lat_r0         <= '0;
      lat_r1         <= '0;
      valid_3a       <= 1'b0;
      alu__cond_3a   <= 1'b0;
      alu__out_3a    <= '0;
      c__branch_3a   <= '0;
      c__to_push_3a  <= '0;
      st__to_pop_3a  <= '0;
      instruction_3a <= '0;
      pc_3a          <= '0;
      r0_3a          <= '0;
      r1_3a          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_2a && !kill_4a && !is_multi) begin
            valid_3a       <= 1'b1;
            alu__out_3a    <= sc_out;
            alu__cond_3a   <= sc_cond;
            c__branch_3a   <= c__branch_2a;
            c__to_push_3a  <= c__to_push_2a;
            st__to_pop_3a  <= st__to_pop_2a;
            instruction_3a <= instruction_2a;
            pc_3a          <= pc_2a;
            if (c__r0_2a) r0_3a <= st__top_0_2a;
            if (c__r1_2a) r1_3a <= st__top_1_2a;
          end else begin
            // Nothing issues this edge: keep stack-side control quiet for the bubble.
            valid_3a      <= 1'b0;
            c__branch_3a  <= '0;
            c__to_push_3a <= '0;
            st__to_pop_3a <= '0;
            if (valid_2a && !kill_4a) begin
              state_q    <= BUSY;
              mc_op_q    <= mc_op_in;
              cnt_q      <= CW'(W - 1);
              acc_q      <= '0;
              a_q        <= (mc_op_in == MC_MUL) ? left : right;
              b_q        <= (mc_op_in == MC_MUL) ? right : left;
              lat_branch <= c__branch_2a;
              lat_push   <= c__to_push_2a;
              lat_pop    <= st__to_pop_2a;
              lat_c_r0   <= c__r0_2a;
              lat_c_r1   <= c__r1_2a;
              lat_insn   <= instruction_2a;
              lat_pc     <= pc_2a;
              lat_r0     <= st__top_0_2a;
              lat_r1     <= st__top_1_2a;
            end
          end
        end
        BUSY: begin
          if (kill_4a) begin
            state_q  <= IDLE;
            valid_3a <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
          end else begin
            acc_q <= it_acc;
            a_q   <= it_a;
            b_q   <= it_b;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              state_q        <= IDLE;
              valid_3a       <= 1'b1;
              alu__out_3a    <= mc_result;
              alu__cond_3a   <= 1'b0;
              c__branch_3a   <= lat_branch;
              c__to_push_3a  <= lat_push;
              st__to_pop_3a  <= lat_pop;
              instruction_3a <= lat_insn;
              pc_3a          <= lat_pc;
              if (lat_c_r0) r0_3a <= lat_r0;
              if (lat_c_r1) r1_3a <= lat_r1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_execute_mc.sv
// Scoreboard bench for cpu_execute_mc: a W=32 instance and a W=16 instance share the clock
// and most stimulus; each has its own valid/reset and an expected-result queue.
module tb_cpu_execute_mc;
  localparam int W = 32, TAG = 3, INSN_W = 48, POP_W = 11, PUSH_W = 3, WB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rst_b, valid, valid_b, kill;
  logic [4:0]        op;
  logic [1:0]        lsel, rsel, branch;
  logic [PUSH_W-1:0] push;
  logic [POP_W-1:0]  pop;
  logic              c_r0, c_r1;
  logic [INSN_W-1:0] insn;
  logic [31:0]       pc;
  logic [W+TAG-1:0]  top0, top1;
  logic [WB+TAG-1:0] top0_b, top1_b;

  logic              stall_a, valid_3a, cond_3a;
  logic [W-1:0]      out_3a;
  logic [1:0]        branch_3a;
  logic [PUSH_W-1:0] push_3a;
  logic [POP_W-1:0]  pop_3a;
  logic [INSN_W-1:0] insn_3a;
  logic [31:0]       pc_3a;
  logic [W+TAG-1:0]  r0_3a, r1_3a;

  logic              stall_b, valid_b3, cond_b3;
  logic [WB-1:0]     out_b3;
  logic [1:0]        branch_b3;
  logic [PUSH_W-1:0] push_b3;
  logic [POP_W-1:0]  pop_b3;
  logic [INSN_W-1:0] insn_b3;
  logic [31:0]       pc_b3;
  logic [WB+TAG-1:0] r0_b3, r1_b3;

  cpu_execute_mc #(.W(W), .TAG(TAG), .INSN_W(INSN_W), .POP_W(POP_W), .PUSH_W(PUSH_W)) dut_a (
    .clk(clk), .rst(rst), .valid_2a(valid), .stall_2a(stall_a), .alu__op_2a(op),
    .c__alu_left_2a(lsel), .c__alu_right_2a(rsel), .c__branch_2a(branch), .c__to_push_2a(push),
    .st__to_pop_2a(pop), .c__r0_2a(c_r0), .c__r1_2a(c_r1), .instruction_2a(insn), .pc_2a(pc),
    .st__top_0_2a(top0), .st__top_1_2a(top1), .kill_4a(kill), .valid_3a(valid_3a),
    .alu__cond_3a(cond_3a), .alu__out_3a(out_3a), .c__branch_3a(branch_3a),
    .c__to_push_3a(push_3a), .st__to_pop_3a(pop_3a), .instruction_3a(insn_3a), .pc_3a(pc_3a),
    .r0_3a(r0_3a), .r1_3a(r1_3a));

  cpu_execute_mc #(.W(WB), .TAG(TAG), .INSN_W(INSN_W), .POP_W(POP_W), .PUSH_W(PUSH_W)) dut_b (
    .clk(clk), .rst(rst_b), .valid_2a(valid_b), .stall_2a(stall_b), .alu__op_2a(op),
    .c__alu_left_2a(lsel), .c__alu_right_2a(rsel), .c__branch_2a(branch), .c__to_push_2a(push),
    .st__to_pop_2a(pop), .c__r0_2a(c_r0), .c__r1_2a(c_r1), .instruction_2a(insn), .pc_2a(pc),
    .st__top_0_2a(top0_b), .st__top_1_2a(top1_b), .kill_4a(kill), .valid_3a(valid_b3),
    .alu__cond_3a(cond_b3), .alu__out_3a(out_b3), .c__branch_3a(branch_b3),
    .c__to_push_3a(push_b3), .st__to_pop_3a(pop_b3), .instruction_3a(insn_b3), .pc_3a(pc_b3),
    .r0_3a(r0_b3), .r1_3a(r1_b3));

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND = 5'd2, OR = 5'd3, XOR = 5'd4, SHL = 5'd5,
                         SHR = 5'd6, EQ = 5'd7, LTU = 5'd8, LTS = 5'd9, MUL = 5'd16,
                         DIVU = 5'd17, REMU = 5'd18;

  typedef struct packed {
    logic [31:0] out;
    logic        cond;
    logic [31:0] pc;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int   n_cmp = 0, n_bad = 0;
  int   last_stall;
  int   tot_stall;
  logic [31:0] next_pc = 32'h100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever a result is presented, pop the oldest expectation for that instance.
  always @(negedge clk) begin
    if (valid_3a === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected: valid_3a with pc %0h, expected none", pc_3a);
      end else begin
        ea = qa.pop_front();
        check("a_out", out_3a, ea.out);
        check("a_cond", cond_3a, ea.cond);
        check("a_pc", pc_3a, ea.pc);
      end
    end
    if (valid_b3 === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected: valid_3a with pc %0h, expected none", pc_b3);
      end else begin
        eb = qb.pop_front();
        check("b_out", out_b3, eb.out);
        check("b_cond", cond_b3, eb.cond);
        check("b_pc", pc_b3, eb.pc);
      end
    end
  end

  task automatic set_op(input logic [4:0] o, input logic [1:0] l, input logic [1:0] r,
                        input logic [31:0] imm, input logic [31:0] t0, input logic [31:0] t1,
                        input logic [31:0] p);
    op = o; lsel = l; rsel = r; pc = p;
    insn   = {16'hA5A5, imm};
    top0   = {3'b101, t0};
    top1   = {3'b010, t1};
    top0_b = {3'b101, t0[15:0]};
    top1_b = {3'b010, t1[15:0]};
    branch = '0; push = '0; pop = '0; c_r0 = 1'b0; c_r1 = 1'b0;
  endtask

  // Present the current inputs until the selected instance accepts them; reports stall cycles.
  task automatic fire(input bit on_b, output int stalls);
    stalls = 0;
    if (on_b) valid_b = 1'b1; else valid = 1'b1;
    while ((on_b ? stall_b : stall_a) && stalls < 200) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 200) check("stall_timeout", 64'(stalls), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; valid_b = 1'b0;
  endtask

  task automatic vec(input bit on_b, input logic [4:0] o, input logic [1:0] l, input logic [1:0] r,
                     input logic [31:0] imm, input logic [31:0] t0, input logic [31:0] t1,
                     input logic [31:0] eo, input logic ec);
    set_op(o, l, r, imm, t0, t1, next_pc);
    if (on_b) qb.push_back('{eo, ec, next_pc}); else qa.push_back('{eo, ec, next_pc});
    fire(on_b, last_stall);
    next_pc += 32'd4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1; valid = 1'b0; valid_b = 1'b0; kill = 1'b0;
    set_op(ADD, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_valid", valid_3a, 0);
    check("rst_out", out_3a, 0);
    check("rst_cond", cond_3a, 0);
    check("rst_pop", pop_3a, 0);
    check("rst_pc", pc_3a, 0);
    check("rst_r0", r0_3a, 0);
    check("rst_r1", r1_3a, 0);
    check("rst_stall", stall_a, 0);

    // Single-cycle stream, back-to-back.
    tot_stall = 0;
    vec(0, ADD, 2'd0, 2'd1, 32'd5, 32'd7, 32'd0, 32'd12, 1'b1);                 tot_stall += last_stall;
    vec(0, SUB, 2'd0, 2'd1, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 1'b1);          tot_stall += last_stall;
    vec(0, AND, 2'd1, 2'd2, 32'd0, 32'hF0F0, 32'hFF00, 32'hF000, 1'b1);         tot_stall += last_stall;
    vec(0, OR,  2'd1, 2'd2, 32'd0, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b1);         tot_stall += last_stall;
    vec(0, XOR, 2'd1, 2'd2, 32'd0, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b1);         tot_stall += last_stall;
    vec(0, XOR, 2'd1, 2'd2, 32'd0, 32'h1234, 32'h1234, 32'd0, 1'b0);            tot_stall += last_stall;
    vec(0, SHL, 2'd1, 2'd0, 32'd33, 32'd1, 32'd0, 32'd2, 1'b1);                 tot_stall += last_stall;
    vec(0, SHR, 2'd1, 2'd0, 32'd31, 32'h8000_0000, 32'd0, 32'd1, 1'b1);         tot_stall += last_stall;
    vec(0, EQ,  2'd3, 2'd3, 32'd9, 32'd4, 32'd6, 32'd1, 1'b1);                  tot_stall += last_stall;
    vec(0, EQ,  2'd1, 2'd2, 32'd0, 32'd7, 32'd8, 32'd0, 1'b0);                  tot_stall += last_stall;
    vec(0, LTU, 2'd1, 2'd2, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);          tot_stall += last_stall;
    vec(0, LTS, 2'd1, 2'd2, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);          tot_stall += last_stall;
    vec(0, 5'd12, 2'd1, 2'd2, 32'd0, 32'd5, 32'd6, 32'd0, 1'b0);                tot_stall += last_stall;
    vec(0, 5'd31, 2'd1, 2'd2, 32'd0, 32'd5, 32'd6, 32'd0, 1'b0);                tot_stall += last_stall;
    vec(0, ADD, 2'd3, 2'd1, 32'd9, 32'd7, 32'd0, 32'd7, 1'b1);                  tot_stall += last_stall;
    check("stream_no_stall", 64'(tot_stall), 64'd0);

    // MUL with r1 capture; top1 changes after accept, r1_3a must keep the accepted value.
    set_op(MUL, 2'd1, 2'd0, 32'd3, 32'hFFFF_FFFF, 32'h0000_ABCD, next_pc);
    c_r1 = 1'b1;
    qa.push_back('{32'hFFFF_FFFD, 1'b0, next_pc});
    fire(0, last_stall);
    next_pc += 32'd4;
    check("mul_accept_no_stall", 64'(last_stall), 64'd0);
    top1 = {3'b111, 32'h1111_1111};
    vec(0, DIVU, 2'd0, 2'd1, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0);
    check("mul_stall_cycles", 64'(last_stall), 64'd32);
    check("mul_r1_latched", r1_3a, {3'b010, 32'h0000_ABCD});
    vec(0, REMU, 2'd0, 2'd1, 32'd100, 32'd7, 32'd0, 32'd2, 1'b0);
    check("divu_stall_cycles", 64'(last_stall), 64'd32);
    vec(0, DIVU, 2'd0, 2'd3, 32'd9, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    vec(0, REMU, 2'd0, 2'd3, 32'd9, 32'd0, 32'd0, 32'd9, 1'b0);
    vec(0, ADD, 2'd0, 2'd1, 32'd1, 32'd1, 32'd0, 32'd2, 1'b1);
    check("remu_stall_cycles", 64'(last_stall), 64'd32);

    // Kill in BUSY cycle 10 of a DIVU; the held SUB issues right after.
    set_op(DIVU, 2'd0, 2'd1, 32'd1000, 32'd3, 32'd0, next_pc);
    next_pc += 32'd4;
    fire(0, last_stall);
    set_op(SUB, 2'd0, 2'd1, 32'd3, 32'd5, 32'd0, next_pc);
    qa.push_back('{32'hFFFF_FFFE, 1'b1, next_pc});
    next_pc += 32'd4;
    valid = 1'b1;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    check("kill_busy_stall_before", stall_a, 1);
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_busy_stall_drop", stall_a, 0);
    check("kill_busy_no_valid", valid_3a, 0);
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Kill in IDLE: control written 0, r0 held, no multi-cycle start.
    set_op(ADD, 2'd0, 2'd1, 32'd1, 32'd0, 32'd0, next_pc);
    c_r0 = 1'b1; pop = 11'd4; branch = 2'd2; push = 3'd5;
    top0 = {3'b101, 32'h1234_5678};
    qa.push_back('{32'h1234_5679, 1'b1, next_pc});
    next_pc += 32'd4;
    fire(0, last_stall);
    check("side_pop", pop_3a, 4);
    check("side_branch", branch_3a, 2);
    check("side_push", push_3a, 5);
    check("side_r0", r0_3a, {3'b101, 32'h1234_5678});
    set_op(MUL, 2'd0, 2'd1, 32'd2, 32'd2, 32'd0, next_pc);
    c_r0 = 1'b1; pop = 11'd4; branch = 2'd2; push = 3'd5;
    top0 = {3'b010, 32'h0000_0042};
    kill = 1'b1; valid = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0; valid = 1'b0;
    check("kill_idle_valid", valid_3a, 0);
    check("kill_idle_pop", pop_3a, 0);
    check("kill_idle_branch", branch_3a, 0);
    check("kill_idle_push", push_3a, 0);
    check("kill_idle_r0_hold", r0_3a, {3'b101, 32'h1234_5678});
    check("kill_idle_no_busy", stall_a, 0);

    // W=16 instance.
    rst_b = 1'b0;
    check("b_rst_valid", valid_b3, 0);
    check("b_rst_out", out_b3, 0);
    check("b_rst_stall", stall_b, 0);
    vec(1, MUL, 2'd0, 2'd1, 32'h0100, 32'h0100, 32'd0, 32'h0000, 1'b0);
    vec(1, MUL, 2'd0, 2'd1, 32'h00FF, 32'h0101, 32'd0, 32'hFFFF, 1'b0);
    check("b_mul_stall_cycles", 64'(last_stall), 64'd16);
    vec(1, DIVU, 2'd0, 2'd3, 32'hFFFF, 32'd0, 32'd0, 32'hFFFF, 1'b0);
    check("b_mul2_stall_cycles", 64'(last_stall), 64'd16);
    set_op(ADD, 2'd0, 2'd1, 32'h7FFF, 32'd1, 32'd0, next_pc);
    c_r0 = 1'b1; pop = 11'd4; branch = 2'd2; push = 3'd5;
    qb.push_back('{32'h8000, 1'b1, next_pc});
    next_pc += 32'd4;
    fire(1, last_stall);
    check("b_divu_stall_cycles", 64'(last_stall), 64'd16);
    check("b_r0_captured", r0_b3, {3'b101, 16'h0001});

    // Reset mid-BUSY clears everything at the next edge.
    set_op(MUL, 2'd0, 2'd1, 32'd5, 32'd6, 32'd0, next_pc);
    next_pc += 32'd4;
    fire(1, last_stall);
    repeat (4) @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk);
    #1 rst_b = 1'b0;
    check("b_midrst_valid", valid_b3, 0);
    check("b_midrst_out", out_b3, 0);
    check("b_midrst_pc", pc_b3, 0);
    check("b_midrst_insn", insn_b3, 0);
    check("b_midrst_r0", r0_b3, 0);
    check("b_midrst_r1", r1_b3, 0);
    check("b_midrst_ctrl", {branch_b3, push_b3, pop_b3, cond_b3}, 0);
    check("b_midrst_stall", stall_b, 0);
    repeat (30) @(posedge clk);
    #1;

    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
